dsp_post_adder_acc: RTL
=======================

Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice.
- Sits directly downstream of the multiplier M pipeline register: consumes the 36-bit product, C, the D:A:B concatenation, PCIN and the carry input.
- Produces P, PCOUT, CARRYOUT and CARRYOUTF through optional pipeline registers, built from reg_mux_block instances.

Parameters:
PREG, 1, 1 = P output registered; 0 = combinational P.
CARRYINREG, 1, 1 = carry-in registered (CYI stage); 0 = pass-through.
CARRYOUTREG, 1, 1 = carry-out registered; 0 = combinational.
CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses opmode[5]; "CARRYIN" uses the carryin port.

Ports:
clk  in  1  Clock; all state updates on the rising edge.
rst  in  1  Reset; asynchronous, active-high; clears every internal register.
cep  in  1  Clock enable for the P register.
cecarryin  in  1  Clock enable for the CYI and carry-out registers.
opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry-in bit, [7] 0 = add / 1 = subtract; bits [6] and [4] are ignored.
m  in  36  Product from the M stage.
c  in  48  C operand.
dab  in  48  {D[11:0], A[17:0], B[17:0]} concatenation.
pcin  in  48  Cascade input from the previous slice.
carryin  in  1  Cascaded carry input.
p  out  48  Result.
pcout  out  48  Copy of p.
carryout  out  1  Adder carry/borrow out.
carryoutf  out  1  Copy of carryout.

Behaviour:
- Reset:
  - While rst = 1: p, pcout, carryout, carryoutf and the CYI register are 0 immediately, with no clock needed.
  - Reset wins over every enable.
  - Deassertion takes effect on the next rising edge.
- X mux:
  - 0 -> 48'd0
  - 1 -> {12'd0, m}
  - 2 -> P feedback
  - 3 -> dab
- Z mux:
  - 0 -> 48'd0
  - 1 -> pcin
  - 2 -> P feedback
  - 3 -> c
- P feedback:
  - Always the P register output.
  - When PREG = 0, feedback selection (X = 2 or Z = 2) yields 48'd0.
  - No combinational loop is permitted.
  - X = 2 with Z = 2 is legal and gives 2·P.
- Carry-in:
  - cin_src is selected by CARRYINSEL.
  - With CARRYINREG = 1, cin_src is captured when cecarryin = 1, so the adder sees the previous cycle's value. This aligns cin with operands delayed by the upstream M register.
  - With CARRYINREG = 0, cin = cin_src.
  - Any CARRYINSEL value other than "OPMODE5" or "CARRYIN" is treated as "OPMODE5".
- Arithmetic, 49-bit unsigned:
  - Add: sum = {0,Z} + {0,X} + cin.
  - Subtract: sum = {0,Z} − ({0,X} + cin).
  - Result = sum[47:0].
  - co = sum[48]: carry for add, borrow (1 = negative) for subtract.
- P register:
  - PREG = 1: p <= result when cep = 1; holds otherwise.
  - Latency from X/Z operands to p is 1 clock.
  - PREG = 0: p = result, 0 latency.
- Carry-out register:
  - CARRYOUTREG = 1: carryout <= co when cecarryin = 1.
  - CARRYOUTREG = 0: combinational.
- Output copies: pcout = p and carryoutf = carryout at all times.
- Accumulation (Z = 2 or X = 2 with PREG = 1):
  - Wraps modulo 2^48.
  - carryout flags each wrap, but only when CARRYOUTREG timing allows, i.e. on the same edge as p.
- Reset mid-accumulation clears P; the next accumulate starts from 0.
- Simultaneous rst and cep: reset wins.

Decomposition:
- Package dsp_post_pkg holds:
  - opmode field indices: X_LSB = 0, Z_LSB = 2, CIN_BIT = 5, SUB_BIT = 7.
  - X/Z select encodings: ZERO, M/PCIN, P, DAB/C.
  - Widths: P_W = 48, M_W = 36.
- Sub-modules: reuse reg_mux_block (RSTTYPE "ASYNC") for three registers:
  - P: BITS 48, SELECTION = PREG.
  - CYI: BITS 1, SELECTION = CARRYINREG.
  - CYO: BITS 1, SELECTION = CARRYOUTREG.
- X/Z muxing and the adder stay in this module; no new sub-module.

Test Plan:
1. Async reset:
   - Stimulus: load p = 48'h123 (pre-load), then assert rst mid-cycle (between edges).
   - Response: p = 0 and carryout = 0 before the next edge; p stays 0 while rst = 1 with cep = 1.
2. Add:
   - Stimulus: opmode = 8'h0D (X = M, Z = C, add, cin = 0), m = 100, c = 5, cep = 1.
   - Response: p = 105 one clock later; carryout = 0.
3. Accumulate:
   - Stimulus: from reset, opmode = 8'h09 (X = M, Z = P), m = 3 for 4 cycles.
   - Response: p = 3, 6, 9, 12. Then cep = 0 for 2 cycles: p holds at 12.
4. Subtract/borrow:
   - Stimulus A: opmode = 8'hAD (sub, cin = opmode[5] = 1), c = 10, m = 3, CARRYINREG = 0.
   - Response A: p = 6, carryout = 0.
   - Stimulus B: c = 0, m = 1, cin = 0.
   - Response B: p = 48'hFFFF_FFFF_FFFF, carryout = 1.
5. Overflow/cascade:
   - Stimulus A: c = 48'hFFFF_FFFF_FFFF, m = 1, add.
   - Response A: p = 0, carryout = 1, carryoutf = 1.
   - Stimulus B: Z = PCIN (opmode[3:2] = 1), pcin = 7, X = 0.
   - Response B: p = pcout = 7.
6. Carry-in register and PREG = 0:
   - Stimulus A: CARRYINSEL = "CARRYIN", CARRYINREG = 1; pulse carryin = 1 for one cycle with X = Z = 0.
   - Response A: p = 1 appears two edges after the pulse.
   - Stimulus B: instance with PREG = 0, CARRYOUTREG = 0.
   - Response B: p follows c + m combinationally; X = 2 yields 0.

Source files
------------

// File: rtl/dsp_post_pkg.sv
// Shared constants, select encodings and the 49-bit post-adder helper
// for the DSP48A1 post-adder/accumulator stage.
package dsp_post_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;

  // opmode field positions
  localparam int X_LSB   = 0;
  localparam int Z_LSB   = 2;
  localparam int CIN_BIT = 5;
  localparam int SUB_BIT = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  // Bit 48 of the result is the carry (add) or borrow (subtract).
  function automatic logic [P_W:0] post_add(input logic           sub,
                                            input logic [P_W-1:0] z,
                                            input logic [P_W-1:0] x,
                                            input logic           cin);
    logic [P_W:0] xc;
    xc = {1'b0, x} + {{P_W{1'b0}}, cin};
    if (sub) post_add = {1'b0, z} - xc;
    else     post_add = {1'b0, z} + xc;
  endfunction

endpackage

// File: rtl/dsp_post_adder_acc_reg_mux_block.sv
// Optional pipeline register: SELECTION = 1 gives a clock-enabled flop,
// SELECTION = 0 a plain wire. RSTTYPE picks async or sync reset.
module reg_mux_block #(
  parameter int    BITS      = 1,
  parameter int    SELECTION = 1,
  parameter string RSTTYPE   = "ASYNC"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  if (SELECTION == 1) begin : g_reg
    logic [BITS-1:0] data_d;
    logic [BITS-1:0] data_q;

    // Hold the stored value unless the enable is set.
    always_comb begin
      data_d = data_q;
      if (ce) data_d = d;
    end

    if (RSTTYPE == "SYNC") begin : g_sync
      // Synchronous-reset storage flop.
      always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
      end
    end else begin : g_async
      // Asynchronous-reset storage flop; reset beats the enable.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
      end
    end

    assign q = data_q;
  end else begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce};
    assign q = d;
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxing, 48-bit add/subtract
// with carry-in, and optional P, carry-in and carry-out registers.
module dsp_post_adder_acc
  import dsp_post_pkg::*;
#(
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cep,
  input  logic           cecarryin,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] dab,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf
);

  // Anything other than "CARRYIN" falls back to the opmode bit.
  localparam bit USE_CIN_PORT = (CARRYINSEL == "CARRYIN");

  logic [P_W-1:0] p_fb;
  logic [P_W-1:0] x_mux;
  logic [P_W-1:0] z_mux;
  logic           cin_src;
  logic           cin;
  logic [P_W:0]   sum;
  logic           co;
  logic           unused_opmode;

  assign unused_opmode = ^{opmode[6], opmode[4]};

  // Feedback always comes from the P flop; without one there is nothing
  // to feed back, and using p here would form a combinational loop.
  if (PREG == 1) begin : g_fb
    assign p_fb = p;
  end else begin : g_nofb
    assign p_fb = '0;
  end

  // X and Z operand selection.
  always_comb begin
    x_sel_e x_sel;
    z_sel_e z_sel;
    x_sel = x_sel_e'(opmode[X_LSB +: 2]);
    z_sel = z_sel_e'(opmode[Z_LSB +: 2]);
    x_mux = '0;
    z_mux = '0;
    case (x_sel)
      X_M:     x_mux = {{(P_W-M_W){1'b0}}, m};
      X_P:     x_mux = p_fb;
      X_DAB:   x_mux = dab;
      default: x_mux = '0;
    endcase
    case (z_sel)
      Z_PCIN:  z_mux = pcin;
      Z_P:     z_mux = p_fb;
      Z_C:     z_mux = c;
      default: z_mux = '0;
    endcase
  end

  assign cin_src = USE_CIN_PORT ? carryin : opmode[CIN_BIT];

  // CYI stage lines the carry up with operands delayed by the M register.
  reg_mux_block #(
    .BITS(1), .SELECTION(CARRYINREG), .RSTTYPE("ASYNC")
  ) u_cyi (
    .clk(clk), .rst(rst), .ce(cecarryin), .d(cin_src), .q(cin)
  );

  // 49-bit adder/subtractor; top bit is carry or borrow.
  always_comb begin
    sum = post_add(opmode[SUB_BIT], z_mux, x_mux, cin);
    co  = sum[P_W];
  end

  reg_mux_block #(
    .BITS(P_W), .SELECTION(PREG), .RSTTYPE("ASYNC")
  ) u_preg (
    .clk(clk), .rst(rst), .ce(cep), .d(sum[P_W-1:0]), .q(p)
  );

  reg_mux_block #(
    .BITS(1), .SELECTION(CARRYOUTREG), .RSTTYPE("ASYNC")
  ) u_cyo (
    .clk(clk), .rst(rst), .ce(cecarryin), .d(co), .q(carryout)
  );

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule
